// File: rtl/unpacked_array_loader_pkg.sv
// ============================================================================
// unpacked_array_loader_pkg
// Shared types and constants for the four-element frame loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package unpacked_array_loader_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/unpacked_array_loader.sv
// ============================================================================
// unpacked_array_loader
// Gathers four WIDTH-bit words into an unpacked array, then holds the frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unpacked_array_loader
  import unpacked_array_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     d,
  output logic [4*WIDTH-1:0]   x
);

  state_e           state_q, state_d;
  idx_t             idx_q, idx_d;
  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] mem_d [0:DEPTH-1];
  logic             w_accept;

  // Reset gates the handshake so nothing is accepted in a reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      if (state_q == FILL) begin
        in_ready = 1'b1;
      end else begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
    end
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    case (state_q)
      FILL: begin
        if (w_accept) begin
          mem_d[idx_q] = in_data;
          idx_d        = idx_q + idx_t'(1);
          if (idx_q == idx_t'(DEPTH - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          if (in_valid) begin
            // Consume and restart in one cycle: the new word becomes element 0.
            mem_d[0] = in_data;
            idx_d    = idx_t'(1);
          end else begin
            idx_d    = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign a = mem_q[0];
  assign b = mem_q[1];
  assign c = mem_q[2];
  assign d = mem_q[3];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
      assign x[gi*WIDTH +: WIDTH] = mem_q[gi];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_unpacked_array_loader.sv
// ============================================================================
// tb_unpacked_array_loader
// Directed self-checking bench for the four-element frame loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unpacked_array_loader;

  localparam int unsigned WIDTH = 32;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   a, b, c, d;
  logic [4*WIDTH-1:0] x;

  int checks;
  int failures;

  unpacked_array_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .x         (x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_frame(input string tag, input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                             input logic [WIDTH-1:0] ec, input logic [WIDTH-1:0] ed);
    check({tag, "_a"}, 128'(a), 128'(ea));
    check({tag, "_b"}, 128'(b), 128'(eb));
    check({tag, "_c"}, 128'(c), 128'(ec));
    check({tag, "_d"}, 128'(d), 128'(ed));
    check({tag, "_x"}, x, {ed, ec, eb, ea});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] held_x;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hdead_beef;
    out_ready = 1'b1;

    // Reset behaviour
    tick();
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    tick();
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("post_rst_x", x, 128'd0);
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    check("post_rst_out_valid", 128'(out_valid), 128'd0);

    // Basic frame, consumed immediately
    send(32'd13);
    send(32'd12);
    send(32'd11);
    check("basic_not_yet", 128'(out_valid), 128'd0);
    send(32'd10);
    check("basic_valid", 128'(out_valid), 128'd1);
    check_frame("basic", 32'd13, 32'd12, 32'd11, 32'd10);
    check("basic_x_literal", x, 128'h0000000a0000000b0000000c0000000d);
    tick();
    check("basic_one_cycle", 128'(out_valid), 128'd0);
    check("basic_back_fill", 128'(in_ready), 128'd1);

    // Backpressure: frame held, input ignored, out_ready ignored in FILL
    out_ready = 1'b0;
    send(32'd13);
    send(32'd12);
    send(32'd11);
    send(32'd10);
    held_x = x;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd99;
      #1;
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_x_stable", x, held_x);
      tick();
    end
    check_frame("bp_frame", 32'd13, 32'd12, 32'd11, 32'd10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 128'(in_ready), 128'd1);
    tick();
    check("bp_consumed", 128'(out_valid), 128'd0);

    // Consume and load first word of next frame in the same cycle
    send(32'd1);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    check("ovl_valid", 128'(out_valid), 128'd1);
    in_valid = 1'b1;
    in_data  = 32'd7;
    #1;
    check("ovl_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    check("ovl_consumed", 128'(out_valid), 128'd0);
    check("ovl_mem0", 128'(a), 128'd7);
    send(32'd20);
    send(32'd21);
    check("ovl_not_yet", 128'(out_valid), 128'd0);
    send(32'd22);
    check("ovl_valid2", 128'(out_valid), 128'd1);
    check_frame("ovl", 32'd7, 32'd20, 32'd21, 32'd22);
    tick();

    // Gaps in in_valid stall the index
    send(32'd1);
    tick();
    tick();
    send(32'd2);
    tick();
    send(32'd3);
    check("gap_not_yet", 128'(out_valid), 128'd0);
    send(32'd4);
    check("gap_valid", 128'(out_valid), 128'd1);
    check_frame("gap", 32'd1, 32'd2, 32'd3, 32'd4);
    tick();

    // Reset mid-fill discards the partial frame
    send(32'd5);
    send(32'd6);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd55;
    #1;
    check("rstfill_in_ready", 128'(in_ready), 128'd0);
    tick();
    check("rstfill_x", x, 128'd0);
    check("rstfill_out_valid", 128'(out_valid), 128'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    send(32'd5);
    send(32'd6);
    send(32'd7);
    check("rstfill_not_yet", 128'(out_valid), 128'd0);
    send(32'd8);
    check("rstfill_valid", 128'(out_valid), 128'd1);
    check_frame("rstfill", 32'd5, 32'd6, 32'd7, 32'd8);

    // Reset while holding drops the pending frame
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("rsthold_out_valid", 128'(out_valid), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rsthold_x", x, 128'd0);
    check("rsthold_fill", 128'(in_ready), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
